// File: rtl/apb_slave_mem_pkg.sv
// Shared APB slave memory package: FSM state type, bus widths, wait-state limit.
package apb_slave_mem_pkg;

   localparam int APB_AW   = 32;
   localparam int APB_DW   = 32;
   localparam int WAIT_MAX = 15;
   localparam int WAIT_CW  = $clog2(WAIT_MAX + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } apb_state_t;

   // An address is usable only if every bit above the word index is zero
   function automatic logic addr_in_range(input logic [APB_AW-1:0] addr, input int awidth);
      return (addr >> (awidth + 2)) == '0;
   endfunction

endpackage

// File: rtl/apb_slave_mem_if.sv
// APB3 bus bundle between a master and the memory slave.
interface apb_slave_mem_if;
   import apb_slave_mem_pkg::*;

   logic              PSEL;
   logic              PENABLE;
   logic              PWRITE;
   logic [APB_AW-1:0] PADDR;
   logic [APB_DW-1:0] PWDATA;
   logic [APB_DW-1:0] PRDATA;
   logic              PREADY;
   logic              PSLVERR;

   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );

endinterface

// File: rtl/apb_slave_ram.sv
// Word memory behind the APB slave: synchronous write, asynchronous read, never reset.
module apb_slave_ram #(
   parameter int AW = 8,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [2**AW];

   // Store the word on the completing edge of a write; contents survive reset
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/apb_slave_mem.sv
// APB3 memory slave with a fixed number of wait states per access phase.
module apb_slave_mem
   import apb_slave_mem_pkg::*;
#(
   parameter int MEM_AWIDTH  = 8,
   parameter int WAIT_CYCLES = 0,
   parameter int TPD         = 1
) (
   input  logic           PCLK,
   input  logic           PRESETN,
   apb_slave_mem_if.slave bus
);

   if (WAIT_CYCLES < 0 || WAIT_CYCLES > WAIT_MAX) begin : g_bad_wait
      $error("apb_slave_mem: WAIT_CYCLES out of range");
   end

   apb_state_t         state;
   logic [WAIT_CW-1:0] wait_cnt;
   logic               pready_q;
   logic [APB_AW-1:0]  addr_q;
   logic [APB_DW-1:0]  wdata_q;
   logic               write_q;
   logic               range_q;

   logic               setup_phase;
   logic               completing;
   logic               ram_we;
   logic [APB_DW-1:0]  ram_rdata;

   logic               unused_addr_bits;
   logic [31:0]        unused_tpd;

   assign setup_phase = bus.PSEL && !bus.PENABLE;
   assign completing  = (state == ACCESS) && pready_q && bus.PSEL && bus.PENABLE;
   assign ram_we      = completing && write_q && range_q;

   // Transfer sequencing: latch the request at setup, count wait states, raise PREADY when they run out
   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         state    <= IDLE;
         wait_cnt <= '0;
         pready_q <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         write_q  <= 1'b0;
         range_q  <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (setup_phase) begin
                  state    <= ACCESS;
                  addr_q   <= bus.PADDR;
                  wdata_q  <= bus.PWDATA;
                  write_q  <= bus.PWRITE;
                  range_q  <= addr_in_range(bus.PADDR, MEM_AWIDTH);
                  wait_cnt <= WAIT_CW'(WAIT_CYCLES);
                  pready_q <= (WAIT_CYCLES == 0);
               end else begin
                  state    <= IDLE;
                  pready_q <= 1'b0;
               end
            end
            ACCESS: begin
               if (!bus.PSEL) begin
                  state    <= IDLE;
                  pready_q <= 1'b0;
               end else if (pready_q && bus.PENABLE) begin
                  state    <= DONE;
                  pready_q <= 1'b0;
               end else begin
                  if (wait_cnt != '0) begin
                     wait_cnt <= wait_cnt - 1'b1;
                  end
                  pready_q <= (wait_cnt <= WAIT_CW'(1));
               end
            end
            default: begin
               state    <= IDLE;
               pready_q <= 1'b0;
            end
         endcase
      end
   end

   apb_slave_ram #(
      .AW (MEM_AWIDTH),
      .DW (APB_DW)
   ) u_ram (
      .clk   (PCLK),
      .we    (ram_we),
      .addr  (addr_q[MEM_AWIDTH+1:2]),
      .wdata (wdata_q),
      .rdata (ram_rdata)
   );

   assign bus.PREADY  = pready_q;
   assign bus.PSLVERR = pready_q && !range_q;
   assign bus.PRDATA  = (pready_q && !write_q && range_q) ? ram_rdata : '0;

   assign unused_addr_bits = ^{addr_q[1:0], addr_q[APB_AW-1:MEM_AWIDTH+2]};
   assign unused_tpd       = TPD;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Scoreboard bench for apb_slave_mem: three instances with 0, 3 and 5 wait states.
module tb_apb_slave_mem;
   import apb_slave_mem_pkg::*;

   localparam int NDUT  = 3;
   localparam int DEPTH = 256;

   typedef struct packed {
      int          dut;
      logic [31:0] rdata;
      logic        slverr;
      int          waits;
   } exp_t;

   logic        clk;
   logic        rst_n   [NDUT];
   logic        psel    [NDUT];
   logic        penable [NDUT];
   logic        pwrite  [NDUT];
   logic [31:0] paddr   [NDUT];
   logic [31:0] pwdata  [NDUT];
   logic [31:0] prdata  [NDUT];
   logic        pready  [NDUT];
   logic        pslverr [NDUT];

   exp_t        sb [$];
   logic [31:0] model_mem [NDUT][DEPTH];
   int          acc_cnt [NDUT];
   int          checks = 0;
   int          errors = 0;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      localparam int W = (g == 0) ? 0 : (g == 1) ? 3 : 5;
      apb_slave_mem_if bus ();
      assign bus.PSEL    = psel[g];
      assign bus.PENABLE = penable[g];
      assign bus.PWRITE  = pwrite[g];
      assign bus.PADDR   = paddr[g];
      assign bus.PWDATA  = pwdata[g];
      assign prdata[g]   = bus.PRDATA;
      assign pready[g]   = bus.PREADY;
      assign pslverr[g]  = bus.PSLVERR;
      apb_slave_mem #(
         .MEM_AWIDTH  (8),
         .WAIT_CYCLES (W),
         .TPD         (1)
      ) dut (
         .PCLK    (clk),
         .PRESETN (rst_n[g]),
         .bus     (bus.slave)
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int waitsOf(input int d);
      return (d == 0) ? 0 : (d == 1) ? 3 : 5;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, expv);
      end
   endtask

   // One complete APB transfer on instance d; the expected response goes to the scoreboard first
   task automatic applyStimulus(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
      exp_t e;
      bit   inr;
      bit   seen;
      int   idx;
      inr      = (addr < 32'd1024);
      idx      = int'(addr / 4) % DEPTH;
      e.dut    = d;
      e.slverr = !inr;
      e.rdata  = (!wr && inr) ? model_mem[d][idx] : 32'h0;
      e.waits  = waitsOf(d);
      if (wr && inr) model_mem[d][idx] = wdata;
      sb.push_back(e);
      psel[d]    = 1'b1;
      penable[d] = 1'b0;
      pwrite[d]  = wr;
      paddr[d]   = addr;
      pwdata[d]  = wdata;
      @(posedge clk);
      #1 penable[d] = 1'b1;
      seen = 1'b0;
      for (int n = 0; n < 40 && !seen; n++) begin
         @(negedge clk);
         seen = pready[d];
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("[TB] FAIL pready_timeout dut=%0d addr=%h actual=0 required=1", d, addr);
      end
      @(posedge clk);
      #1;
      psel[d]    = 1'b0;
      penable[d] = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: every completed transfer is matched against the oldest scoreboard entry
   always @(negedge clk) begin
      for (int d = 0; d < NDUT; d++) begin
         if (pready[d] === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("[TB] FAIL unexpected_pready dut=%0d actual=1 required=0", d);
            end else begin
               exp_t e;
               e = sb.pop_front();
               if (e.dut != d || prdata[d] !== e.rdata || pslverr[d] !== e.slverr || acc_cnt[d] != e.waits) begin
                  errors++;
                  $display("[TB] FAIL response dut=%0d actual data=%h err=%b waits=%0d required dut=%0d data=%h err=%b waits=%0d",
                           d, prdata[d], pslverr[d], acc_cnt[d], e.dut, e.rdata, e.slverr, e.waits);
               end
            end
            acc_cnt[d] = 0;
         end else begin
            if (psel[d] && penable[d]) begin
               acc_cnt[d]++;
               checks++;
               if (prdata[d] !== 32'h0 || pslverr[d] !== 1'b0) begin
                  errors++;
                  $display("[TB] FAIL notready_outputs dut=%0d actual data=%h err=%b required data=0 err=0",
                           d, prdata[d], pslverr[d]);
               end
            end
            if (!psel[d]) acc_cnt[d] = 0;
         end
      end
   end

   initial begin
      for (int d = 0; d < NDUT; d++) begin
         rst_n[d]   = 1'b0;
         psel[d]    = 1'b0;
         penable[d] = 1'b0;
         pwrite[d]  = 1'b0;
         paddr[d]   = 32'h0;
         pwdata[d]  = 32'h0;
         acc_cnt[d] = 0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < NDUT; d++) begin
         checkOutput("reset_pready", 32'(pready[d]), 32'h0);
         checkOutput("reset_pslverr", 32'(pslverr[d]), 32'h0);
         checkOutput("reset_prdata", prdata[d], 32'h0);
      end
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) rst_n[d] = 1'b1;

      // fill every word of every instance; low address bits are random and must be ignored
      for (int d = 0; d < NDUT; d++)
         for (int w = 0; w < DEPTH; w++)
            applyStimulus(d, 1'b1, 32'(w * 4 + $urandom_range(0, 3)), $urandom());

      // zero-wait write then read
      applyStimulus(0, 1'b1, 32'h10, 32'hDEADBEEF);
      applyStimulus(0, 1'b0, 32'h10, 32'h0);
      // three wait states on a read
      applyStimulus(1, 1'b0, 32'h10, 32'h0);
      // out-of-range write must not alias onto word 0
      applyStimulus(0, 1'b1, 32'h400, 32'h12345678);
      applyStimulus(0, 1'b0, 32'h000, 32'h0);
      // last word, read back through an unaligned address
      applyStimulus(0, 1'b1, 32'h3FC, 32'hA5A5A5A5);
      applyStimulus(0, 1'b0, 32'h3FF, 32'h0);
      // back-to-back transfers with no idle cycles
      applyStimulus(0, 1'b1, 32'h0, 32'h11112222);
      applyStimulus(0, 1'b1, 32'h4, 32'h33334444);
      applyStimulus(0, 1'b0, 32'h0, 32'h0);
      applyStimulus(0, 1'b0, 32'h4, 32'h0);
      idleCycles(2);

      // reset during the second access cycle of a five-wait write
      psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = 32'h20; pwdata[2] = 32'h1;
      @(posedge clk);
      #1 penable[2] = 1'b1;
      @(posedge clk);
      #1 rst_n[2] = 1'b0;
      #1;
      checkOutput("abort_reset_pready", 32'(pready[2]), 32'h0);
      checkOutput("abort_reset_pslverr", 32'(pslverr[2]), 32'h0);
      checkOutput("abort_reset_prdata", prdata[2], 32'h0);
      psel[2] = 1'b0; penable[2] = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n[2] = 1'b1;
      applyStimulus(2, 1'b0, 32'h20, 32'h0);

      // PSEL dropped mid-access: no write may land
      psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 32'h24; pwdata[1] = 32'hFFFF0000;
      @(posedge clk);
      #1 penable[1] = 1'b1;
      @(posedge clk);
      #1 psel[1] = 1'b0; penable[1] = 1'b0;
      idleCycles(2);
      applyStimulus(1, 1'b0, 32'h24, 32'h0);

      // access phase without a setup phase is ignored
      psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = 32'h8; pwdata[0] = 32'hCAFEF00D;
      idleCycles(3);
      psel[0] = 1'b0; penable[0] = 1'b0;
      idleCycles(1);
      applyStimulus(0, 1'b0, 32'h8, 32'h0);

      // randomized traffic across all instances, some out of range, mixed gaps
      for (int i = 0; i < 300; i++) begin
         int          d;
         logic [31:0] a;
         d = int'($urandom_range(0, NDUT - 1));
         a = ($urandom_range(0, 7) == 0) ? $urandom() : 32'($urandom_range(0, 1023));
         applyStimulus(d, 1'($urandom_range(0, 1)), a, $urandom());
         if ($urandom_range(0, 1) == 1) idleCycles(int'($urandom_range(1, 2)));
      end

      idleCycles(4);
      checkOutput("scoreboard_drained", 32'(sb.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/apb_slave_mem.md
APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

Interface
REQ-001 SHALL have parameter MEM_AWIDTH, default 8, meaning log2 of memory depth in 32-bit words.
REQ-002 SHALL have parameter WAIT_CYCLES, default 0, legal range 0..15, meaning wait states inserted per access phase.
REQ-003 SHALL have parameter TPD, default 1, meaning output delay in ns, simulation only.
REQ-004 SHALL have port PCLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port PRESETN, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port PSEL, input, 1 bit: slave select.
REQ-007 SHALL have port PENABLE, input, 1 bit: access phase indicator.
REQ-008 SHALL have port PWRITE, input, 1 bit: 1 = write, 0 = read.
REQ-009 SHALL have port PADDR, input, 32 bits: byte address.
REQ-010 SHALL have port PWDATA, input, 32 bits: write data.
REQ-011 SHALL have port PRDATA, output, 32 bits: read data.
REQ-012 SHALL have port PREADY, output, 1 bit: transfer completion.
REQ-013 SHALL have port PSLVERR, output, 1 bit: transfer error, qualified by PREADY.

Function
REQ-014 SHALL implement an APB3 slave backed by a 2^MEM_AWIDTH x 32 memory.
- Word index = PADDR[MEM_AWIDTH+1:2].
- PADDR[1:0] ignored.
REQ-015 SHALL treat an address as in range iff PADDR[31:MEM_AWIDTH+2] == 0; any other address is out of range.
REQ-016 SHALL use FSM states IDLE, ACCESS, DONE.
- IDLE->ACCESS on PSEL=1 & PENABLE=0 (setup phase).
- ACCESS->DONE when PREADY=1 is sampled with PSEL=1 & PENABLE=1.
- DONE->ACCESS on a new setup phase; DONE->IDLE otherwise.
REQ-017 SHALL, at the setup-phase edge, latch PADDR, PWRITE, PWDATA and the in-range flag, and load the wait counter with WAIT_CYCLES.
REQ-018 SHALL decrement the wait counter by 1 each ACCESS cycle while it is nonzero; the counter saturates at 0.
REQ-019 SHALL drive PREADY = 1 only in ACCESS with counter == 0, decoded from registers only (no combinational path from APB inputs).
- Access phase therefore lasts exactly WAIT_CYCLES+1 cycles.
REQ-020 SHALL drive PREADY = 0 in IDLE and DONE.
REQ-021 SHALL perform a write only at the completing edge (ACCESS, PREADY=1, PSEL=1, PENABLE=1, latched write=1, in range), using the latched address and data.
REQ-022 SHALL drive PRDATA for an in-range read as mem[latched index] whenever PREADY=1.
REQ-023 SHALL drive PRDATA = 0 when PREADY=0, for all writes, and for out-of-range reads.
REQ-024 SHALL drive PSLVERR = 1 only while PREADY=1 for an out-of-range access; out-of-range writes SHALL NOT modify memory.
REQ-025 SHALL, if PSEL falls while in ACCESS (protocol abort), return to IDLE next edge without any memory write.
REQ-026 SHALL support back-to-back transfers: setup in the cycle after completion is accepted from DONE with no extra idle cycle.
REQ-027 SHALL ignore PSEL=1 & PENABLE=1 seen in IDLE (no setup phase): no state change, no write.

Reset
REQ-028 SHALL, on PRESETN low, asynchronously force state=IDLE, counter=0, PREADY=0, PSLVERR=0, PRDATA=0, and latched address/data/write/range flags=0.
REQ-029 SHALL NOT clear memory contents on reset; contents persist across reset.
REQ-030 SHALL abort any transfer in progress when reset is asserted, with no memory write.
REQ-031 SHALL accept a setup phase on the first rising PCLK edge after PRESETN deasserts.

Structure
REQ-032 SHALL take the FSM state enum, the APB data/address width constants (32) and the WAIT_CYCLES maximum (15) from the shared BFM package.
REQ-033 SHALL place the memory array in a sub-module apb_slave_ram: one synchronous write port and one asynchronous read port, no reset.

Verification
REQ-034 Bench SHALL run this case: WAIT_CYCLES=0; write 0xDEADBEEF to 0x10, then read 0x10 -> each access phase is 1 cycle; PRDATA=0xDEADBEEF; PSLVERR=0.
REQ-035 Bench SHALL run this case: WAIT_CYCLES=3; read 0x10 -> PREADY low for 3 access cycles, high on the 4th; PRDATA=0 until PREADY=1.
REQ-036 Bench SHALL run this case: MEM_AWIDTH=8; write 0x12345678 to 0x400 -> PSLVERR=1 with PREADY; a subsequent read of 0x000 returns its prior value (no aliasing write).
REQ-037 Bench SHALL run this case: write 0xA5A5A5A5 to 0x3FC (last word), then read 0x3FF -> PRDATA=0xA5A5A5A5; PSLVERR=0.
REQ-038 Bench SHALL run this case: WAIT_CYCLES=5; assert PRESETN low during the 2nd access cycle of a write of 0x1 to 0x20 -> all outputs 0 immediately; a read of 0x20 after reset returns the old value.
REQ-039 Bench SHALL run this case: back-to-back writes to 0x0 and 0x4, then reads of 0x0 and 0x4 with no idle cycles -> all four complete; data matches; no PSLVERR.
